prog_clk_div: RTL and testbench
===============================

PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter CNT_W, default 27: width of each channel's counter and terminal value.
REQ-002 Parameter N_CH, default 4: number of independent divider channels.
REQ-003 Parameter DEF_T, default 2**(CNT_W-1)-1: terminal value loaded at reset (period 2**CNT_W cycles).
REQ-004 Port CLK  input  1: the only clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port en  input  N_CH: per-channel run enable.
REQ-007 Port cfg_we  input  1: one-cycle configuration write strobe.
REQ-008 Port cfg_ch  input  clog2(N_CH) (min 1): target channel of the write.
REQ-009 Port cfg_val  input  CNT_W: new terminal value T.
REQ-010 Port clk_out  output  N_CH: divided clocks, 50% duty.
REQ-011 Port tick  output  N_CH: one-cycle pulse at each rising transition of clk_out.
REQ-012 Port pend  output  N_CH: a written terminal value awaits application.

Function
REQ-013 Each channel SHALL hold a counter cnt, an active terminal act_T, a pending terminal pnd_T and the flag pend.
REQ-014 Enabled channel: cnt SHALL increment per cycle; when cnt==act_T, cnt SHALL wrap to 0 and clk_out SHALL toggle on that edge ("wrap").
REQ-015 The output period SHALL be 2*(act_T+1) cycles; T=0 gives CLK/2; T=2**CNT_W-1 SHALL be legal, without overflow.
REQ-016 tick SHALL be 1 exactly in the cycle after clk_out goes 0->1 is registered, i.e. tick is registered alongside clk_out and high for one cycle per output period.
REQ-017 en[ch]=0: cnt SHALL be cleared to 0, clk_out and tick forced 0 on the next edge; resuming starts a fresh full low half-period.
REQ-018 A write (cfg_we=1, cfg_ch<N_CH) SHALL load pnd_T and set pend on the next edge.
REQ-019 Writes with cfg_ch>=N_CH SHALL be ignored with no state change.
REQ-020 On a wrap with pend=1, act_T SHALL take pnd_T and pend SHALL clear; the output SHALL never produce a half-period shorter than min(old T, new T)+1 cycles.
REQ-021 If the channel is disabled, a write SHALL update act_T directly and pend SHALL stay 0.
REQ-022 A write on the same edge as a wrap SHALL go to pnd_T and apply at the following wrap; a second write before application SHALL overwrite pnd_T.

Reset
REQ-023 rst_n=0 SHALL immediately set every cnt=0, act_T=pnd_T=DEF_T, pend=0, clk_out=0, tick=0 regardless of CLK.
REQ-024 After rst_n deasserts, an enabled channel's first clk_out rise SHALL occur at edge DEF_T+1 counted from the first active edge.
REQ-025 Reset mid-period SHALL discard any pending write.

Configuration
REQ-026 Macro PROG_CLK_DIV_TICK_EN: when defined, tick SHALL behave per REQ-016; when undefined, tick SHALL be tied to 0 and its register logic omitted, the port list unchanged.

Structure
REQ-027 Package clk_div_pkg SHALL hold the default CNT_W, the default N_CH and the channel-index width constant.
REQ-028 One sub-module clk_div_ch SHALL implement a single channel (REQ-013..022) and be instantiated N_CH times.
REQ-029 Top level SHALL only decode cfg_ch into per-channel write enables and concatenate outputs.

Verification
REQ-030 Reset, en=all 1, no writes, CNT_W=4 -> clk_out rises every 16 cycles, first rise at edge 8.
REQ-031 Write T=0 to ch1 while disabled, then enable -> clk_out[1]=CLK/2, tick[1] high every 2nd cycle, pend[1] never set.
REQ-032 Ch0 running T=5, write T=2 mid-half-period -> pend[0]=1 until the next wrap; that half-period stays 6 cycles, then 3-cycle halves.
REQ-033 Write coincident with wrap, then a second write T=9 before the next wrap -> T=9 applied at the following wrap, first value never used.
REQ-034 cfg_ch=N_CH write, then rst_n pulsed low mid-period -> no state change from the write; all outputs 0 asynchronously, pend cleared.
REQ-035 Build without PROG_CLK_DIV_TICK_EN -> tick constant 0, clk_out identical to REQ-030.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and channel-index width helper for prog_clk_div.
package clk_div_pkg;
    localparam int CNT_W_DEF = 27;
    localparam int N_CH_DEF  = 4;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int CH_W_DEF = ch_w(N_CH_DEF);
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one programmable 50%-duty divider channel; terminal updates land on a wrap.
// The tick register exists only when PROG_CLK_DIV_TICK_EN is defined.
module clk_div_ch #(
    parameter int               CNT_W = 27,
    parameter logic [CNT_W-1:0] DEF_T = {1'b0, {(CNT_W-1){1'b1}}}
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [CNT_W-1:0] val,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    logic [CNT_W-1:0] cnt_q, cnt_d, act_t_q, act_t_d, pnd_t_q, pnd_t_d;
    logic             pend_q, pend_d, clk_out_q, clk_out_d, wrap;
    assign wrap = en && cnt_q == act_t_q;
    always_comb begin
        cnt_d     = (en && !wrap) ? cnt_q + CNT_W'(1) : '0;
        clk_out_d = en && (clk_out_q ^ wrap);
        pnd_t_d   = we ? val : pnd_t_q;
        // an idle channel has no wrap to wait for, so updates apply at once
        act_t_d   = !en ? (we ? val : (pend_q ? pnd_t_q : act_t_q))
                        : ((wrap && pend_q) ? pnd_t_q : act_t_q);
        pend_d    = en && (we || (pend_q && !wrap));
    end
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            act_t_q   <= DEF_T;
            pnd_t_q   <= DEF_T;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_t_q   <= act_t_d;
            pnd_t_q   <= pnd_t_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
        end
    end
    assign clk_out = clk_out_q;
    assign pend    = pend_q;
`ifdef PROG_CLK_DIV_TICK_EN
    logic tick_q, tick_d;
    always_comb tick_d = wrap && !clk_out_q;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) tick_q <= 1'b0;
        else        tick_q <= tick_d;
    end
    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif
endmodule

// File: rtl/prog_clk_div.sv
// prog_clk_div: N_CH independent programmable 50%-duty clock dividers.
// Define PROG_CLK_DIV_TICK_EN to enable the tick outputs (tied 0 otherwise).
module prog_clk_div
    import clk_div_pkg::*;
#(
    parameter int               CNT_W = CNT_W_DEF,
    parameter int               N_CH  = N_CH_DEF,
    parameter logic [CNT_W-1:0] DEF_T = {1'b0, {(CNT_W-1){1'b1}}}
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         en,
    input  logic                    cfg_we,
    input  logic [ch_w(N_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]        cfg_val,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         pend
);
    logic [N_CH-1:0] ch_we;
    // out-of-range channel numbers match no channel and are dropped
    always_comb for (int i = 0; i < N_CH; i++) ch_we[i] = cfg_we && int'(cfg_ch) == i;
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_ch #(.CNT_W(CNT_W), .DEF_T(DEF_T)) u_ch (
            .CLK     (CLK),
            .rst_n   (rst_n),
            .en      (en[g]),
            .we      (ch_we[g]),
            .val     (cfg_val),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pend    (pend[g])
        );
    end
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: directed table of per-row stimulus and hand-computed outputs,
// plus hand-written sequences for async reset and the maximum terminal value.
module tb_prog_clk_div;
    localparam int CNT_W = 4;
    localparam int N_CH  = 3;
`ifdef PROG_CLK_DIV_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif
    typedef struct {
        logic [2:0] en;
        logic       we;
        logic [1:0] ch;
        logic [3:0] val;
        int         n;
        logic [2:0] clk;
        logic [2:0] tick;
        logic [2:0] pend;
    } vec_t;

    logic             CLK = 1'b0;
    logic             rst_n;
    logic [N_CH-1:0]  en;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_val;
    logic [N_CH-1:0]  clk_out, tick, pend;
    int checks = 0;
    int errors = 0;
    vec_t tbl[32];

    prog_clk_div #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_val (cfg_val),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t row(input logic [2:0] e, input logic w, input logic [1:0] c,
                                 input logic [3:0] v, input int n, input logic [2:0] ck,
                                 input logic [2:0] tk, input logic [2:0] pd);
        vec_t r;
        r.en = e; r.we = w; r.ch = c; r.val = v; r.n = n; r.clk = ck; r.tick = tk; r.pend = pd;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        // {en, we, ch, val, edges, clk_out, tick, pend}; bit order {ch2, ch1, ch0}
        tbl[0]  = row(3'b111, 0, 0, 0, 7, 3'b000, 3'b000, 3'b000);
        tbl[1]  = row(3'b111, 0, 0, 0, 1, 3'b111, 3'b111, 3'b000);
        tbl[2]  = row(3'b111, 0, 0, 0, 1, 3'b111, 3'b000, 3'b000);
        tbl[3]  = row(3'b111, 0, 0, 0, 6, 3'b111, 3'b000, 3'b000);
        tbl[4]  = row(3'b111, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[5]  = row(3'b111, 0, 0, 0, 8, 3'b111, 3'b111, 3'b000);
        tbl[6]  = row(3'b101, 0, 0, 0, 1, 3'b101, 3'b000, 3'b000);
        tbl[7]  = row(3'b101, 1, 1, 0, 1, 3'b101, 3'b000, 3'b000);
        tbl[8]  = row(3'b111, 0, 0, 0, 1, 3'b111, 3'b010, 3'b000);
        tbl[9]  = row(3'b111, 0, 0, 0, 1, 3'b101, 3'b000, 3'b000);
        tbl[10] = row(3'b111, 0, 0, 0, 1, 3'b111, 3'b010, 3'b000);
        tbl[11] = row(3'b111, 0, 0, 0, 2, 3'b111, 3'b010, 3'b000);
        tbl[12] = row(3'b111, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000);
        tbl[13] = row(3'b110, 1, 0, 5, 1, 3'b010, 3'b010, 3'b000);
        tbl[14] = row(3'b111, 0, 0, 0, 6, 3'b011, 3'b011, 3'b000);
        tbl[15] = row(3'b111, 0, 0, 0, 1, 3'b101, 3'b100, 3'b000);
        tbl[16] = row(3'b111, 1, 0, 2, 1, 3'b111, 3'b010, 3'b001);
        tbl[17] = row(3'b111, 0, 0, 0, 3, 3'b101, 3'b000, 3'b001);
        tbl[18] = row(3'b111, 0, 0, 0, 1, 3'b110, 3'b010, 3'b000);
        tbl[19] = row(3'b111, 0, 0, 0, 2, 3'b110, 3'b010, 3'b000);
        tbl[20] = row(3'b111, 0, 0, 0, 1, 3'b001, 3'b001, 3'b000);
        tbl[21] = row(3'b111, 0, 0, 0, 3, 3'b010, 3'b010, 3'b000);
        tbl[22] = row(3'b111, 0, 0, 0, 3, 3'b001, 3'b001, 3'b000);
        tbl[23] = row(3'b111, 0, 0, 0, 2, 3'b101, 3'b100, 3'b000);
        tbl[24] = row(3'b111, 1, 0, 4, 1, 3'b110, 3'b010, 3'b001);
        tbl[25] = row(3'b111, 1, 0, 9, 1, 3'b100, 3'b000, 3'b001);
        tbl[26] = row(3'b111, 0, 0, 0, 2, 3'b101, 3'b001, 3'b000);
        tbl[27] = row(3'b111, 0, 0, 0, 5, 3'b011, 3'b010, 3'b000);
        tbl[28] = row(3'b111, 0, 0, 0, 5, 3'b000, 3'b000, 3'b000);
        tbl[29] = row(3'b111, 1, 3, 0, 1, 3'b010, 3'b010, 3'b000);
        tbl[30] = row(3'b111, 0, 0, 0, 1, 3'b100, 3'b100, 3'b000);
        tbl[31] = row(3'b111, 1, 2, 1, 1, 3'b110, 3'b010, 3'b100);

        rst_n = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_val = '0;
        #2;
        chk("reset_clk_out", -1, clk_out, 3'b000);
        chk("reset_tick", -1, tick, 3'b000);
        chk("reset_pend", -1, pend, 3'b000);
        @(negedge CLK);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            en = tbl[i].en; cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_val = tbl[i].val;
            tick_n(1);
            cfg_we = 1'b0;
            if (tbl[i].n > 1) tick_n(tbl[i].n - 1);
            chk("clk_out", i, clk_out, tbl[i].clk);
            chk("tick", i, tick, TICK_ON ? tbl[i].tick : 3'b000);
            chk("pend", i, pend, tbl[i].pend);
        end

        // ch2 holds a pending write here; reset must clear everything without a clock edge
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_out", 100, clk_out, 3'b000);
        chk("async_rst_tick", 100, tick, 3'b000);
        chk("async_rst_pend", 100, pend, 3'b000);
        tick_n(2);
        @(negedge CLK);
        rst_n = 1'b1;
        tick_n(7);
        chk("post_rst_low", 101, clk_out, 3'b000);
        chk("post_rst_pend", 101, pend, 3'b000);
        tick_n(1);
        chk("post_rst_rise", 102, clk_out, 3'b111);
        chk("post_rst_tick", 102, tick, TICK_ON ? 3'b111 : 3'b000);

        // maximum terminal value: 16-cycle halves on ch0
        en = 3'b110; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_val = 4'hf;
        tick_n(1);
        cfg_we = 1'b0; en = 3'b111;
        tick_n(15);
        chk("tmax_low", 103, {2'b00, clk_out[0]}, 3'b000);
        tick_n(1);
        chk("tmax_rise", 104, {2'b00, clk_out[0]}, 3'b001);
        chk("tmax_pend", 104, pend, 3'b000);
        tick_n(15);
        chk("tmax_high", 105, {2'b00, clk_out[0]}, 3'b001);
        tick_n(1);
        chk("tmax_fall", 106, {2'b00, clk_out[0]}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
